// File: rtl/regfile_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_if
// Description : Bundle of write-back, decode read, HI/LO and debug signals
//               between the pipeline and the architectural register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Write-back
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;

    // Decode-stage read ports
    logic              re1;
    logic              re2;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    // Debug port: one extra address bit selects HI/LO/reserved
    logic              dbg_req;
    logic [ADDR_W:0]   dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, hi_o, lo_o,
        output dbg_req, dbg_addr,
        input  dbg_ack, dbg_data
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, hi_o, lo_o,
        input  dbg_req, dbg_addr,
        output dbg_ack, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb
// Description : 32x32 GPR file plus HI/LO with write-through bypass on all
//               reads and a four-phase registered debug snapshot port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,        // active-low, asynchronous assert
    regfile_wb_if.slave bus
);

    localparam int c_NUM_REGS = 1 << ADDR_W;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_ACK  = 1'b1;

    logic [DATA_W-1:0] w_gpr [0:c_NUM_REGS-1];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_dbg_sel;
    logic [ADDR_W-1:0] w_dbg_idx;
    logic [0:0]        r_state;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_dbg_data;

    // One flop bank per register; r0 is a constant so it never needs storage.
    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_REGS; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                assign w_gpr[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_q <= '0;
                    end else if (bus.wb_wreg && (bus.wb_wd == ADDR_W'(gi))) begin
                        r_q <= bus.wb_wdata;
                    end
                end
                assign w_gpr[gi] = r_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (bus.wb_whilo) begin
            r_hi <= bus.wb_hi;
            r_lo <= bus.wb_lo;
        end
    end

    assign w_hi = bus.wb_whilo ? bus.wb_hi : r_hi;
    assign w_lo = bus.wb_whilo ? bus.wb_lo : r_lo;

    always_comb begin
        w_rdata1 = '0;
        if (bus.re1 && (bus.raddr1 != '0)) begin
            if (bus.wb_wreg && (bus.wb_wd == bus.raddr1)) begin
                w_rdata1 = bus.wb_wdata;
            end else begin
                w_rdata1 = w_gpr[bus.raddr1];
            end
        end
    end

    always_comb begin
        w_rdata2 = '0;
        if (bus.re2 && (bus.raddr2 != '0)) begin
            if (bus.wb_wreg && (bus.wb_wd == bus.raddr2)) begin
                w_rdata2 = bus.wb_wdata;
            end else begin
                w_rdata2 = w_gpr[bus.raddr2];
            end
        end
    end

    // Debug selection mirrors a bypassed read so a capture sees post-write state.
    assign w_dbg_idx = bus.dbg_addr[ADDR_W-1:0];

    always_comb begin
        w_dbg_sel = '0;
        if (!bus.dbg_addr[ADDR_W]) begin
            if (w_dbg_idx != '0) begin
                if (bus.wb_wreg && (bus.wb_wd == w_dbg_idx)) begin
                    w_dbg_sel = bus.wb_wdata;
                end else begin
                    w_dbg_sel = w_gpr[w_dbg_idx];
                end
            end
        end else if (w_dbg_idx == ADDR_W'(0)) begin
            w_dbg_sel = w_hi;
        end else if (w_dbg_idx == ADDR_W'(1)) begin
            w_dbg_sel = w_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_S_IDLE;
            r_dbg_ack  <= 1'b0;
            r_dbg_data <= '0;
        end else if (r_state == c_S_IDLE) begin
            if (bus.dbg_req) begin
                r_state    <= c_S_ACK;
                r_dbg_ack  <= 1'b1;
                r_dbg_data <= w_dbg_sel;
            end
        end else begin
            if (!bus.dbg_req) begin
                r_state   <= c_S_IDLE;
                r_dbg_ack <= 1'b0;
            end
        end
    end

    assign bus.rdata1   = w_rdata1;
    assign bus.rdata2   = w_rdata2;
    assign bus.hi_o     = w_hi;
    assign bus.lo_o     = w_lo;
    assign bus.dbg_ack  = r_dbg_ack;
    assign bus.dbg_data = r_dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb
// Description : Directed self-checking bench for regfile_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.wb_wd    = '0;
        bus.wb_wreg  = 1'b0;
        bus.wb_wdata = '0;
        bus.wb_hi    = '0;
        bus.wb_lo    = '0;
        bus.wb_whilo = 1'b0;
        bus.re1      = 1'b0;
        bus.re2      = 1'b0;
        bus.raddr1   = '0;
        bus.raddr2   = '0;
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = '0;
        #2;
        check("rst_ack", {31'd0, bus.dbg_ack}, 32'd0);
        check("rst_dbgdata", bus.dbg_data, 32'd0);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // All GPRs read zero after reset on both ports
        bus.re1 = 1'b1;
        bus.re2 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.raddr1 = 5'(a);
            bus.raddr2 = 5'(31 - a);
            #1;
            check("rst_rd1", bus.rdata1, 32'd0);
            check("rst_rd2", bus.rdata2, 32'd0);
        end

        // Debug reads of HI and LO after reset
        for (int a = 32; a < 34; a++) begin
            bus.dbg_req  = 1'b1;
            bus.dbg_addr = 6'(a);
            tick();
            check("dbg_hilo_ack", {31'd0, bus.dbg_ack}, 32'd1);
            check("dbg_hilo_data", bus.dbg_data, 32'd0);
            bus.dbg_req = 1'b0;
            tick();
            check("dbg_hilo_rel", {31'd0, bus.dbg_ack}, 32'd0);
        end

        // Write r5 with same-cycle bypass, then from storage
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd5;
        bus.wb_wdata = 32'hDEADBEEF;
        bus.raddr1   = 5'd5;
        bus.raddr2   = 5'd6;
        #1;
        check("byp_r5", bus.rdata1, 32'hDEADBEEF);
        check("byp_other", bus.rdata2, 32'd0);
        tick();
        bus.wb_wreg  = 1'b0;
        bus.wb_wdata = 32'h0;
        #1;
        check("store_r5", bus.rdata1, 32'hDEADBEEF);
        bus.raddr2 = 5'd5;
        #1;
        check("store_r5_p2", bus.rdata2, 32'hDEADBEEF);
        bus.re1 = 1'b0;
        #1;
        check("re1_off", bus.rdata1, 32'd0);
        bus.re1 = 1'b1;

        // Writes to r0 are discarded
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd0;
        bus.wb_wdata = 32'hFFFFFFFF;
        bus.raddr1   = 5'd0;
        bus.raddr2   = 5'd0;
        #1;
        check("r0_byp1", bus.rdata1, 32'd0);
        check("r0_byp2", bus.rdata2, 32'd0);
        tick();
        bus.wb_wreg = 1'b0;
        #1;
        check("r0_st1", bus.rdata1, 32'd0);
        check("r0_st2", bus.rdata2, 32'd0);

        // HI/LO bypass and hold
        bus.wb_whilo = 1'b1;
        bus.wb_hi    = 32'h12345678;
        bus.wb_lo    = 32'h9ABCDEF0;
        #1;
        check("hi_byp", bus.hi_o, 32'h12345678);
        check("lo_byp", bus.lo_o, 32'h9ABCDEF0);
        tick();
        bus.wb_whilo = 1'b0;
        bus.wb_hi    = 32'h11111111;
        bus.wb_lo    = 32'h22222222;
        #1;
        check("hi_hold", bus.hi_o, 32'h12345678);
        check("lo_hold", bus.lo_o, 32'h9ABCDEF0);

        // Debug capture on the same edge as a write to r7
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd7;
        bus.wb_wdata = 32'hA5A5A5A5;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 6'd7;
        #1;
        check("dbg_pre_ack", {31'd0, bus.dbg_ack}, 32'd0);
        tick();
        bus.wb_wreg  = 1'b0;
        bus.dbg_addr = 6'd5;
        #1;
        check("dbg_r7_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("dbg_r7_data", bus.dbg_data, 32'hA5A5A5A5);
        tick();
        tick();
        check("dbg_hold_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("dbg_hold_data", bus.dbg_data, 32'hA5A5A5A5);
        bus.dbg_req = 1'b0;
        #1;
        check("dbg_fall_pre", {31'd0, bus.dbg_ack}, 32'd1);
        tick();
        check("dbg_fall_ack", {31'd0, bus.dbg_ack}, 32'd0);
        check("dbg_keep_data", bus.dbg_data, 32'hA5A5A5A5);

        // Stored GPR and stored HI through debug
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 6'd5;
        tick();
        check("dbg_r5", bus.dbg_data, 32'hDEADBEEF);
        bus.dbg_req = 1'b0;
        tick();
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 6'd32;
        tick();
        check("dbg_hi", bus.dbg_data, 32'h12345678);
        bus.dbg_req = 1'b0;
        tick();
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 6'd33;
        tick();
        check("dbg_lo", bus.dbg_data, 32'h9ABCDEF0);
        bus.dbg_req = 1'b0;
        tick();

        // Reserved address captures zero
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 6'd40;
        tick();
        check("dbg_rsv_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("dbg_rsv_data", bus.dbg_data, 32'd0);
        bus.dbg_req = 1'b0;
        tick();

        // Reset while in ACK
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd3;
        bus.wb_wdata = 32'h00000055;
        tick();
        bus.wb_wreg  = 1'b0;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 6'd3;
        bus.raddr1   = 5'd3;
        tick();
        check("pre_rst_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("pre_rst_data", bus.dbg_data, 32'h00000055);
        check("pre_rst_r3", bus.rdata1, 32'h00000055);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ack", {31'd0, bus.dbg_ack}, 32'd0);
        check("mid_rst_data", bus.dbg_data, 32'd0);
        check("mid_rst_r3", bus.rdata1, 32'd0);
        check("mid_rst_hi", bus.hi_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.wb_wreg  = 1'b1;
        bus.wb_wd    = 5'd3;
        bus.wb_wdata = 32'h00000077;
        #1;
        check("post_rst_idle", {31'd0, bus.dbg_ack}, 32'd0);
        tick();
        bus.wb_wreg = 1'b0;
        check("post_rst_ack", {31'd0, bus.dbg_ack}, 32'd1);
        check("post_rst_data", bus.dbg_data, 32'h00000077);
        bus.dbg_req = 1'b0;
        tick();
        check("post_rst_rel", {31'd0, bus.dbg_ack}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
